// File: rtl/flick_cond_pkg.sv
// Shared types and constants for the FLICK button conditioner.
// Provides the debounce FSM state encoding and press counter sizing.
package flick_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    localparam int PRESS_CNT_W = 8;
    localparam logic [PRESS_CNT_W-1:0] PRESS_CNT_MAX = 8'hff;

    // Saturating increment used by the press counter.
    function automatic logic [PRESS_CNT_W-1:0] sat_inc(
        input logic [PRESS_CNT_W-1:0] v
    );
        return (v == PRESS_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous level input.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// FLICK push-button conditioner: synchronise, debounce, one-cycle pulse per
// accepted press, debounced level and saturating press counter.
// Ports: CLK, RST (sync, active-high), BTN_IN (async) -> FLICK (1-cycle
// pulse), BTN_STABLE (debounced level), PRESS_CNT[7:0] (saturating count).
// Optional auto-repeat while held: define FLICK_REPEAT_EN.
module flick_conditioner
    import flick_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   BTN_IN,
    output logic                   FLICK,
    output logic                   BTN_STABLE,
    output logic [PRESS_CNT_W-1:0] PRESS_CNT
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("flick_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("flick_conditioner: REPEAT_DELAY/PERIOD must be >= 1");
    end

    logic       synced;
    state_t     state;
    logic [CNT_W-1:0] deb_cnt;
    logic       accept;
    logic       rep_fire;
    logic       pulse;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (BTN_IN),
        .q   (synced)
    );

    // Press is accepted on the D-th consecutive high sample in PRESS_WAIT.
    assign accept = (state == PRESS_WAIT) && synced && (deb_cnt == DEB_LAST);

`ifdef FLICK_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_WRAP  =
        REP_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nxt;
    logic             rep_run;

    // Counts only cycles spent in HELD with the button still down; it
    // folds back to REP_FIRST so it never needs more than DELAY+PERIOD.
    assign rep_run  = (state == HELD) && synced;
    assign rep_nxt  = rep_cnt + 1'b1;
    assign rep_fire = rep_run &&
                      ((rep_nxt == REP_FIRST) || (rep_nxt == REP_WRAP));

    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_cnt <= '0;
        end else if (accept || state == IDLE) begin
            rep_cnt <= '0;
        end else if (rep_run) begin
            rep_cnt <= (rep_nxt == REP_WRAP) ? REP_FIRST : rep_nxt;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign pulse = accept || rep_fire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (synced) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!synced) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!synced) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (synced) begin
                        state   <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            FLICK     <= 1'b0;
            PRESS_CNT <= '0;
        end else begin
            FLICK <= pulse;
            if (pulse) begin
                PRESS_CNT <= sat_inc(PRESS_CNT);
            end
        end
    end

    assign BTN_STABLE = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_flick_conditioner.sv
// Randomised scoreboard bench for flick_conditioner.
// Reference model works on run lengths of the synchronised input.
module tb_flick_conditioner;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_IN = 1'b0;
    logic       FLICK;
    logic       BTN_STABLE;
    logic [7:0] PRESS_CNT;

    always #5 CLK = ~CLK;

    flick_conditioner #(
        .SYNC_STAGES     (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN_IN     (BTN_IN),
        .FLICK      (FLICK),
        .BTN_STABLE (BTN_STABLE),
        .PRESS_CNT  (PRESS_CNT)
    );

    typedef struct {
        bit flick;
        bit stable;
        int cnt;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model: the button value seen N edges late; level flips once the
    // seen value has differed from it for D+1 consecutive edges.
    bit   hq[$];
    bit   prev_s;
    int   run;
    bit   lvl;
    int   k;
    int   m_cnt;

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < N; i++) hq.push_back(1'b0);
        prev_s = 1'b0;
        run    = 1;
        lvl    = 1'b0;
        k      = 0;
        m_cnt  = 0;
    endtask

    task automatic step(input bit rst, input bit btn);
        exp_t e;
        bit   s;
        bit   f;
        @(negedge CLK);
        RST    = rst;
        BTN_IN = btn;
        f      = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            s = hq.pop_front();
            hq.push_back(btn);
            if (s == prev_s) begin
                if (run < 100000) run++;
            end else begin
                run = 1;
            end
            if (s != lvl && run >= D + 1) begin
                lvl = s;
                if (s) begin
                    f = 1'b1;
                    k = 0;
                end
            end else if (lvl && s && prev_s) begin
                k++;
`ifdef FLICK_REPEAT_EN
                if (k == RD || (k > RD && (k - RD) % RP == 0)) f = 1'b1;
`endif
            end
            prev_s = s;
            if (f && m_cnt < 255) m_cnt++;
        end
        e.flick  = f;
        e.stable = lvl;
        e.cnt    = m_cnt;
        expq.push_back(e);
    endtask

    task automatic hold(input bit btn, input int n);
        for (int i = 0; i < n; i++) step(1'b0, btn);
    endtask

    task automatic settle();
        @(posedge CLK);
        #3;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one expected response per clock edge, compared after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (FLICK !== e.flick || BTN_STABLE !== e.stable ||
                    PRESS_CNT !== 8'(e.cnt)) begin
                    failures++;
                    $display("FAIL cycle %0d: got flick=%b stable=%b cnt=%0d expected flick=%b stable=%b cnt=%0d",
                             cyc, FLICK, BTN_STABLE, PRESS_CNT,
                             e.flick, e.stable, e.cnt);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lv;
        int len;
        model_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        settle();
        chk("reset_flick", FLICK, 0);
        chk("reset_stable", BTN_STABLE, 0);
        chk("reset_cnt", PRESS_CNT, 0);
        hold(1'b0, 3);

        // Clean press and release.
        hold(1'b1, 20);
        settle();
        chk("clean_stable", BTN_STABLE, 1);
        chk("clean_cnt_min", PRESS_CNT >= 1, 1);
        chk("clean_cnt", PRESS_CNT, m_cnt);
        hold(1'b0, 12);
        settle();
        chk("clean_release", BTN_STABLE, 0);

        // Press bounce.
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 20);
        hold(1'b0, 12);
        settle();
        chk("bounce_cnt", PRESS_CNT, m_cnt);

        // Short glitch: no pulse.
        len = m_cnt;
        hold(1'b1, 2);
        hold(1'b0, 12);
        settle();
        chk("glitch_cnt", PRESS_CNT, len);
        chk("glitch_stable", BTN_STABLE, 0);

        // Release bounce.
        hold(1'b1, 20);
        len = m_cnt;
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 10);
        settle();
        chk("relbounce_cnt", PRESS_CNT, len);
        chk("relbounce_stable", BTN_STABLE, 0);

        // Reset in the middle of PRESS_WAIT.
        hold(1'b1, 5);
        step(1'b1, 1'b1);
        settle();
        chk("midrst_flick", FLICK, 0);
        chk("midrst_stable", BTN_STABLE, 0);
        chk("midrst_cnt", PRESS_CNT, 0);
        hold(1'b1, 20);
        hold(1'b0, 12);
        settle();
        chk("midrst_repress", PRESS_CNT, m_cnt);

        // Long hold (auto-repeat when enabled).
        hold(1'b1, 30);
        hold(1'b0, 12);
        settle();
        chk("longhold_cnt", PRESS_CNT, m_cnt);

        // Randomised bouncing with occasional resets.
        lv = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            lv = ~lv;
            if ($urandom_range(0, 9) == 0) len = $urandom_range(10, 40);
            else len = $urandom_range(1, D + 3);
            if ($urandom_range(0, 199) == 0) step(1'b1, lv);
            hold(lv, len);
        end
        hold(1'b0, 12);

        // Saturation after many clean presses.
        step(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        settle();
        chk("sat_cnt", PRESS_CNT, 255);

        hold(1'b0, 3);
        settle();
        chk("drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
